// File: rtl/nn_sample_sequencer_if.sv
// Handshake bundle between the sample sequencer, its word source, the neuron and the result consumer.
// slave = sequencer side, master = environment side.
interface nn_sample_sequencer_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;

    logic [N-1:0] nn_x1;
    logic [N-1:0] nn_x2;
    logic [N-1:0] nn_x3;
    logic [N-1:0] nn_x4;
    logic         nn_start;
    logic         nn_done;
    logic [N-1:0] nn_out;

    logic         res_valid;
    logic [N-1:0] res_data;
    logic         res_ready;

    modport slave (
        input  in_valid, in_data, nn_done, nn_out, res_ready,
        output in_ready, nn_x1, nn_x2, nn_x3, nn_x4, nn_start, res_valid, res_data
    );

    modport master (
        output in_valid, in_data, nn_done, nn_out, res_ready,
        input  in_ready, nn_x1, nn_x2, nn_x3, nn_x4, nn_start, res_valid, res_data
    );
endinterface

// File: rtl/nn_sample_sequencer.sv
// Packs four input words into a neuron sample, launches the neuron and returns its result.
// Optional WAIT watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_sample_sequencer #(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    nn_sample_sequencer_if.slave  bus,
    output logic                  busy,
    output logic [15:0]           sample_cnt,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t            state;
    logic [3:0][N-1:0] shadow;
    logic [1:0]        word_idx;
    logic              shadow_full;
    logic              accept;
    logic              launch;
    logic              res_take;
    logic              timeout_hit;

    // A zero limit would expire on WAIT entry; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign bus.in_ready = !shadow_full;
    assign accept       = bus.in_valid && !shadow_full;
    assign res_take     = bus.res_valid && bus.res_ready;
    assign launch       = (state == IDLE) && shadow_full && (!bus.res_valid || bus.res_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            word_idx    <= 2'd0;
            shadow_full <= 1'b0;
        end else if (accept) begin
            shadow[word_idx] <= bus.in_data;
            word_idx         <= word_idx + 2'd1;
            if (word_idx == 2'd3) shadow_full <= 1'b1;
        end else if (launch) begin
            shadow_full <= 1'b0;
        end
    end

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // wait_cnt counts completed WAIT cycles, so the limit is hit in the TIMEOUT_CYCLES-th one.
    assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT) wait_cnt <= '0;
            else               wait_cnt <= wait_cnt + TW'(1);
            if (timeout_hit && !bus.nn_done) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.nn_start  <= 1'b0;
            busy          <= 1'b0;
            bus.nn_x1     <= '0;
            bus.nn_x2     <= '0;
            bus.nn_x3     <= '0;
            bus.nn_x4     <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            sample_cnt    <= 16'd0;
        end else begin
            bus.nn_start <= 1'b0;
            if (res_take) bus.res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state        <= START;
                        bus.nn_start <= 1'b1;
                        busy         <= 1'b1;
                        bus.nn_x1    <= shadow[0];
                        bus.nn_x2    <= shadow[1];
                        bus.nn_x3    <= shadow[2];
                        bus.nn_x4    <= shadow[3];
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // done beats the watchdog when both land in the same cycle
                    if (bus.nn_done) begin
                        bus.res_data  <= bus.nn_out;
                        bus.res_valid <= 1'b1;
                        sample_cnt    <= sample_cnt + 16'd1;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Randomized self-checking bench for nn_sample_sequencer with a behavioural neuron and sample scoreboard.
module tb_nn_sample_sequencer;
    localparam int N = 32;
`ifdef NN_SEQ_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 1023;
`endif

    typedef logic [3:0][N-1:0] sample_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sample_cnt;

    nn_sample_sequencer_if #(.N(N)) bus ();

    nn_sample_sequencer #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .sample_cnt (sample_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;
    int exp_samples = 0;

    function automatic logic [N-1:0] nf(input sample_t s);
        return (s[0] + (s[1] * 3)) ^ (s[2] - s[3]);
    endfunction

    // Neuron model: done exactly lat cycles after the start cycle, result nf(operands).
    int          lat = 5;
    bit          model_en = 1'b1;
    logic        extra_done = 1'b0;
    logic        model_done;
    bit          m_busy;
    int          m_cnt;
    int          m_lat;
    sample_t     m_ops;
    logic [N-1:0] junk = 32'h5A5A0F0F;

    assign bus.nn_done = model_done | extra_done;
    assign bus.nn_out  = model_done ? nf(m_ops) : junk;

    always @(posedge clk) begin
        if (rst) begin
            model_done <= 1'b0;
            m_busy     <= 1'b0;
            m_cnt      <= 0;
        end else begin
            model_done <= 1'b0;
            if (bus.nn_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_lat  <= lat;
                m_ops  <= {bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1};
            end else if (m_busy) begin
                if (m_cnt >= m_lat - 1) begin
                    if (model_en) begin
                        model_done <= 1'b1;
                        m_busy     <= 1'b0;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // Scoreboard: accepted words -> ordered samples -> expected results.
    logic [N-1:0] wq[$];
    sample_t      sq[$];
    logic [N-1:0] rq[$];
    int           acc_total = 0;
    int           starts    = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                wq.push_back(bus.in_data);
                acc_total++;
                if (wq.size() == 4) begin : pack
                    sample_t t;
                    for (int i = 0; i < 4; i++) t[i] = wq[i];
                    sq.push_back(t);
                    wq.delete();
                end
            end
            if (bus.nn_start) begin
                starts++;
                nchk++;
                if (sq.size() == 0) begin
                    $display("FAIL start_without_sample: nn_start with no assembled sample");
                end else begin : chk_ops
                    sample_t e;
                    e = sq.pop_front();
                    rq.push_back(nf(e));
                    if ({bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1} !== e)
                        $display("FAIL operands: got %h want %h",
                                 {bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1}, e);
                    else npass++;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                nchk++;
                if (rq.size() == 0) begin
                    $display("FAIL result_unexpected: res_data %h with none pending", bus.res_data);
                end else begin : chk_res
                    logic [N-1:0] r;
                    r = rq.pop_front();
                    if (bus.res_data !== r) $display("FAIL result: got %h want %h", bus.res_data, r);
                    else npass++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] d);
        bit ok;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            ok = bus.in_ready;
            step();
            n++;
        end while (!ok && n < 200);
        bus.in_valid = 1'b0;
        if (!ok) begin
            nchk++;
            $display("FAIL send_word: word %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.nn_start && n < 300) begin step(); n++; end
        if (!bus.nn_start) begin
            nchk++;
            $display("FAIL wait_start: no nn_start within 300 cycles");
        end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!bus.res_valid && n < 300) begin step(); n++; end
        if (!bus.res_valid) begin
            nchk++;
            $display("FAIL wait_res: no res_valid within 300 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        nchk++; if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready: got %b want 1", tag, bus.in_ready); else npass++;
        nchk++; if ({bus.nn_x1, bus.nn_x2, bus.nn_x3, bus.nn_x4} !== '0)
            $display("FAIL %s nn_x: got %h want 0", tag, {bus.nn_x1, bus.nn_x2, bus.nn_x3, bus.nn_x4}); else npass++;
        nchk++; if ({bus.nn_start, bus.res_valid, busy, timeout_err} !== 4'b0)
            $display("FAIL %s start/res_valid/busy/timeout: got %b want 0000", tag,
                     {bus.nn_start, bus.res_valid, busy, timeout_err}); else npass++;
        nchk++; if (bus.res_data !== '0) $display("FAIL %s res_data: got %h want 0", tag, bus.res_data); else npass++;
        nchk++; if (sample_cnt !== 16'd0) $display("FAIL %s sample_cnt: got %0d want 0", tag, sample_cnt); else npass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.res_ready = 1'b0;
        extra_done = 1'b0;
        model_en = 1'b1;
        wq.delete(); sq.delete(); rq.delete();
        step(); step();
        rst = 1'b0;
        check_reset_outputs("reset");
        exp_samples = 0;
    endtask

    task automatic test_basic();
        int c;
        sample_t e;
        lat = 5;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e[i] = N'(i + 1);
            send_word(N'(i + 1));
        end
        nchk++; if ({bus.nn_start, bus.in_ready} !== 2'b00)
            $display("FAIL basic_prelaunch start/in_ready: got %b want 00", {bus.nn_start, bus.in_ready}); else npass++;
        step();
        nchk++; if ({bus.nn_start, bus.in_ready, busy} !== 3'b111)
            $display("FAIL basic_launch start/in_ready/busy: got %b want 111", {bus.nn_start, bus.in_ready, busy}); else npass++;
        nchk++; if ({bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1} !== e)
            $display("FAIL basic_operands: got %h want %h", {bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1}, e); else npass++;
        step();
        nchk++; if (bus.nn_start !== 1'b0) $display("FAIL basic_single_pulse: got %b want 0", bus.nn_start); else npass++;
        wait_res(c);
        // result appears lat+1 cycles after the start cycle; we began counting one cycle in
        nchk++; if (c !== lat) $display("FAIL basic_latency: got %0d want %0d", c, lat); else npass++;
        nchk++; if (bus.res_data !== nf(e)) $display("FAIL basic_res_data: got %h want %h", bus.res_data, nf(e)); else npass++;
        exp_samples++;
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL basic_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
        step();
    endtask

    task automatic test_backpressure();
        sample_t a, b;
        int s0, c;
        bus.res_ready = 1'b0;
        s0 = starts;
        for (int i = 0; i < 4; i++) a[i] = $urandom;
        for (int i = 0; i < 4; i++) b[i] = $urandom;
        for (int i = 0; i < 4; i++) send_word(a[i]);
        for (int i = 0; i < 4; i++) send_word(b[i]);
        nchk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else npass++;
        repeat (20) step();
        nchk++; if ({bus.res_valid, busy, bus.in_ready} !== 3'b100)
            $display("FAIL bp_hold valid/busy/in_ready: got %b want 100", {bus.res_valid, busy, bus.in_ready}); else npass++;
        nchk++; if (bus.res_data !== nf(a)) $display("FAIL bp_held_data: got %h want %h", bus.res_data, nf(a)); else npass++;
        nchk++; if (starts - s0 !== 1) $display("FAIL bp_start_count: got %0d want 1", starts - s0); else npass++;
        bus.res_ready = 1'b1;
        step();
        nchk++; if ({bus.nn_start, bus.res_valid} !== 2'b10)
            $display("FAIL bp_relaunch start/res_valid: got %b want 10", {bus.nn_start, bus.res_valid}); else npass++;
        wait_res(c);
        nchk++; if (bus.res_data !== nf(b)) $display("FAIL bp_second_data: got %h want %h", bus.res_data, nf(b)); else npass++;
        exp_samples += 2;
        step();
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL bp_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
    endtask

    task automatic test_partial();
        sample_t e;
        int s0, c;
        s0 = starts;
        for (int i = 0; i < 4; i++) e[i] = $urandom;
        for (int i = 0; i < 3; i++) send_word(e[i]);
        repeat (20) step();
        nchk++; if (starts - s0 !== 0) $display("FAIL partial_early_start: got %0d want 0", starts - s0); else npass++;
        nchk++; if ({bus.in_ready, busy} !== 2'b10)
            $display("FAIL partial_idle in_ready/busy: got %b want 10", {bus.in_ready, busy}); else npass++;
        send_word(e[3]);
        step();
        nchk++; if (bus.nn_start !== 1'b1) $display("FAIL partial_launch: got %b want 1", bus.nn_start); else npass++;
        nchk++; if ({bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1} !== e)
            $display("FAIL partial_order: got %h want %h", {bus.nn_x4, bus.nn_x3, bus.nn_x2, bus.nn_x1}, e); else npass++;
        wait_res(c);
        exp_samples++;
        step();
    endtask

    task automatic test_done_ignored();
        int c;
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        nchk++; if ({bus.res_valid, busy} !== 2'b00)
            $display("FAIL done_idle valid/busy: got %b want 00", {bus.res_valid, busy}); else npass++;
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL done_idle_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
        for (int i = 0; i < 4; i++) send_word($urandom);
        step();
        nchk++; if (bus.nn_start !== 1'b1) $display("FAIL done_start_cycle: got %b want 1", bus.nn_start); else npass++;
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        nchk++; if ({bus.res_valid, busy} !== 2'b01)
            $display("FAIL done_start valid/busy: got %b want 01", {bus.res_valid, busy}); else npass++;
        wait_res(c);
        exp_samples++;
        step();
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL done_final_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
    endtask

    task automatic test_reset_mid();
        int c;
        lat = 40;
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_start();
        step();
        send_word($urandom);
        send_word($urandom);
        nchk++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else npass++;
        rst = 1'b1;
        wq.delete(); sq.delete(); rq.delete();
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        lat = 5;
        exp_samples = 0;
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_start();
        wait_res(c);
        exp_samples++;
        step();
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL midrst_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
    endtask

    task automatic test_random();
        int target, base, cyc;
        target = 4 * $urandom_range(20, 30);
        base = acc_total;
        cyc = 0;
        while (acc_total - base < target && cyc < 5000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = $urandom;
            bus.res_ready = ($urandom_range(0, 9) < 5);
            lat = $urandom_range(2, 8);
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        cyc = 0;
        while ((sq.size() != 0 || rq.size() != 0 || busy || bus.res_valid) && cyc < 500) begin
            step();
            cyc++;
        end
        nchk++; if (acc_total - base !== target) $display("FAIL rand_words: got %0d want %0d", acc_total - base, target); else npass++;
        nchk++; if (sq.size() + rq.size() !== 0) $display("FAIL rand_drain: %0d samples still pending want 0", sq.size() + rq.size()); else npass++;
        exp_samples += target / 4;
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL rand_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
    endtask

`ifdef NN_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        model_en = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_start();
        repeat (TO) step();
        nchk++; if ({timeout_err, busy} !== 2'b01)
            $display("FAIL to_before err/busy: got %b want 01", {timeout_err, busy}); else npass++;
        step();
        nchk++; if ({timeout_err, busy, bus.res_valid} !== 3'b100)
            $display("FAIL to_after err/busy/valid: got %b want 100", {timeout_err, busy, bus.res_valid}); else npass++;
        nchk++; if (sample_cnt !== 16'(exp_samples)) $display("FAIL to_count: got %0d want %0d", sample_cnt, exp_samples); else npass++;
        repeat (5) step();
        nchk++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else npass++;
        rq.delete();
        model_en = 1'b1;
        test_reset();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_partial();
        test_done_ignored();
        test_reset_mid();
        test_random();
`ifdef NN_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/nn_sample_sequencer.md
# nn_sample_sequencer

Upstream feeder for the four-input neuron top level. Accepts a serial stream of 32-bit input words over a valid/ready handshake, packs four consecutive words into one sample, launches the neuron with a one-cycle `nn_start` pulse, waits for `nn_done`, and returns the neuron output on a valid/ready result port. A shadow register lets the next sample load while the current one computes.

## Interface
- `N`, 32: data width of input words, neuron operands and result.
- `TIMEOUT_CYCLES`, 1023: watchdog limit in WAIT. Used only with `NN_SEQ_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_data`  in  N  input word; word 0 → `nn_x1` … word 3 → `nn_x4`.
- `in_ready`  out  1  sequencer accepts a word this cycle.
- `nn_x1`, `nn_x2`, `nn_x3`, `nn_x4`  out  N each  operands to the neuron; held stable from launch until the next launch.
- `nn_start`  out  1  one-cycle launch pulse to the neuron.
- `nn_done`  in  1  neuron completion.
- `nn_out`  in  N  neuron result; sampled when `nn_done` is seen.
- `res_valid`  out  1  result register holds an unconsumed result.
- `res_data`  out  N  result value.
- `res_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in START or WAIT.
- `sample_cnt`  out  16  completed samples; wraps from 0xFFFF to 0.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Reset values: `in_ready`=1, all `nn_x*`=0, `nn_start`=0, `res_valid`=0, `res_data`=0, `busy`=0, `sample_cnt`=0, `timeout_err`=0. Internal state: word index 0, `shadow_full`=0, FSM in IDLE.
- Assembly:
  - `in_ready` = `!shadow_full`.
  - On `in_valid && in_ready`, write `in_data` into shadow slot `word_idx`, then increment `word_idx`.
  - Accepting slot 3 sets `shadow_full` and wraps `word_idx` to 0.
  - Words are never dropped. A partial sample persists across any number of idle cycles.
- FSM states: IDLE, START, WAIT.
  - IDLE → START when `shadow_full && (!res_valid || res_ready)`. In the same edge, copy the shadow into `nn_x1..4` and clear `shadow_full`.
  - START: `nn_start`=1 for exactly this cycle. Always → WAIT.
  - WAIT: on `nn_done`=1, capture `res_data`←`nn_out`, set `res_valid`, increment `sample_cnt`, → IDLE. `nn_done` is ignored in every state other than WAIT.
- Result port:
  - `res_valid` clears on `res_valid && res_ready`.
  - A result capture and a consume in the same cycle cannot occur, because launch requires the result slot to be free or freeing.
- Simultaneous events:
  - A launch and an input-word acceptance never share a cycle, since `in_ready`=0 while `shadow_full`.
  - Filling of the next shadow proceeds during START and WAIT.
- Reset mid-operation: an in-flight sample, partial shadow and pending result are discarded. The neuron shares `rst`.
- No arithmetic beyond counters. `sample_cnt` wraps modulo 2^16.

## Timing
- Fourth word accepted at edge t → `shadow_full`=1 in cycle t+1.
- If the FSM is in IDLE, launch happens at edge t+1. `nn_x*` and `nn_start`=1 are then valid in cycle t+2, and `in_ready` returns to 1 in the same cycle.
- `nn_done` high in cycle d (in WAIT) → `res_valid`=1 and the new `res_data` appear in cycle d+1.
- The earliest next launch edge is d+1 (one IDLE cycle), giving its `nn_start` in cycle d+2.
- Minimum spacing between `nn_start` pulses is 3 cycles plus neuron latency.

## Configuration
- Macro `NN_SEQ_TIMEOUT_EN`.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `nn_done`, set `timeout_err` (sticky until `rst`) and return to IDLE.
  - A timed-out sample produces no result, and `sample_cnt` is unchanged.
  - A `nn_done` arriving in the same cycle the counter reaches the limit wins: the result is captured and no error is raised.
- Undefined: WAIT lasts until `nn_done` with no limit. `timeout_err` is tied to 0 and no counter is built.

## Test plan
- Reset, then stream 1,2,3,4 back-to-back with `res_ready`=1 and a neuron model with done after 5 cycles. Expect `nn_x1..4`=1,2,3,4, a single `nn_start` pulse two cycles after word 4, `res_data`=model output, and `sample_cnt`=1.
- Stream 8 words continuously with `res_ready`=0. Expect the first result to be held, `in_ready`=0 after word 8, and no second `nn_start` until `res_ready` pulses. Then the second launch fires in that same cycle's edge.
- Send 3 words, idle 20 cycles, then send a 4th. Expect no launch until the 4th word, and operands in the original order.
- Pulse `nn_done` during IDLE and START. Expect it ignored: no `res_valid` and no count change.
- Assert `rst` in WAIT with a half-filled shadow. Expect all outputs at reset values the next cycle, and a fresh 4-word sample to launch normally.
- With `NN_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, the model never asserts done. Expect `timeout_err`=1 after 10 WAIT cycles, return to IDLE, and `sample_cnt` unchanged.
